hy_riscv_fetch_issue: RTL and testbench



---
 rtl/hy_riscv_pkg.sv | 60 ++++++
 rtl/hy_riscv_next_pc.sv | 28 ++
 rtl/hy_riscv_fetch_issue.sv | 184 ++++++++++++++++++
 tb/tb_hy_riscv_fetch_issue.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hy_riscv_pkg.sv
// Shared definitions for the hy_riscv front end: opcode constants, the
// fetch/issue state encoding, immediate extraction and the capture-stage
// decode used to classify a freshly read instruction word.
package hy_riscv_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    // Fetch/issue sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_RESOLVE = 3'd4,
        ST_HALTED  = 3'd5
    } fetch_state_e;

    // Outcome of inspecting a word in CAPTURE
    typedef enum logic [1:0] {
        DEC_ISSUE = 2'd0,
        DEC_HALT  = 2'd1,
        DEC_FAULT = 2'd2
    } capture_decode_e;

    // B-type immediate, sign-extended, bit 0 always zero
    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // J-type immediate, sign-extended, bit 0 always zero
    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // Classify a fetched word. SYSTEM and (optionally) all-zero words stop
    // the unit cleanly; compressed/illegal encodings and JALR (whose target
    // depends on a register value the front end never sees) are faults.
    function automatic capture_decode_e decode_word(input logic [31:0] instr,
                                                    input logic halt_on_zero);
        capture_decode_e result;
        result = DEC_ISSUE;
        if (instr[6:0] == OP_SYSTEM) begin
            result = DEC_HALT;
        end else if (halt_on_zero && (instr == 32'd0)) begin
            result = DEC_HALT;
        end else if (instr[1:0] != 2'b11) begin
            result = DEC_FAULT;
        end else if (instr[6:0] == OP_JALR) begin
            result = DEC_FAULT;
        end
        return result;
    endfunction

endpackage

// File: rtl/hy_riscv_next_pc.sv
// Combinational next-PC generation for the RESOLVE state: selects the
// increment (4, branch offset or jump offset), adds it to the current PC
// modulo 2^32 and flags a target that is not word aligned.
module hy_riscv_next_pc
    import hy_riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] offset;

    // Pick the PC increment from the issued opcode and the CPU's branch result
    always_comb begin
        offset = 32'd4;
        if (instr[6:0] == OP_JAL) begin
            offset = imm_j(instr);
        end else if ((instr[6:0] == OP_BRANCH) && branch_taken) begin
            offset = imm_b(instr);
        end
        next_pc    = pc + offset;
        misaligned = (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/hy_riscv_fetch_issue.sv
// Instruction fetch and issue front end for hy_riscv_cpu. Walks the PC
// through a 1-cycle synchronous instruction SRAM, pushes each legal word to
// the CPU, then uses the CPU's registered branch result to pick the next PC.
// One instruction takes four cycles: FETCH, CAPTURE, ISSUE, RESOLVE.
module hy_riscv_fetch_issue
    import hy_riscv_pkg::*;
#(
    parameter int IMEM_AW      = 10,
    parameter int HALT_ON_ZERO = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [31:0]        boot_pc,
    input  logic               stop,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               push_ops,
    output logic [31:0]        opcode,
    input  logic               branch_taken,
    output logic [31:0]        pc,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [31:0]        retired
);

    fetch_state_e    state_reg;
    fetch_state_e    state_next;

    logic [31:0]     pc_reg;
    logic [31:0]     opcode_reg;
    logic            push_ops_reg;
    logic            busy_reg;
    logic            halted_reg;
    logic            fault_reg;
    logic [31:0]     retired_reg;

    // Datapath controls produced by the sequencer
    logic            load_boot;
    logic            load_next;
    logic            set_fault;
    logic            load_opcode;
    logic            inc_retired;

    capture_decode_e capture_class;
    logic [31:0]     resolved_pc;
    logic            resolved_misaligned;

    // The opcode register doubles as the instruction register: it only takes
    // a new word when that word is going to be issued, so it stays stable
    // between pushes and RESOLVE always sees the instruction just issued.
    assign capture_class = decode_word(imem_rdata, HALT_ON_ZERO != 0);

    hy_riscv_next_pc u_next_pc (
        .pc           (pc_reg),
        .instr        (opcode_reg),
        .branch_taken (branch_taken),
        .next_pc      (resolved_pc),
        .misaligned   (resolved_misaligned)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and datapath control decode
    always_comb begin
        state_next  = state_reg;
        load_boot   = 1'b0;
        load_next   = 1'b0;
        set_fault   = 1'b0;
        load_opcode = 1'b0;
        inc_retired = 1'b0;
        case (state_reg)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    load_boot = 1'b1;
                    if (boot_pc[1:0] != 2'b00) begin
                        set_fault  = 1'b1;
                        state_next = ST_HALTED;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                case (capture_class)
                    DEC_ISSUE: begin
                        load_opcode = 1'b1;
                        state_next  = ST_ISSUE;
                    end
                    DEC_HALT: begin
                        state_next = ST_HALTED;
                    end
                    default: begin
                        set_fault  = 1'b1;
                        state_next = ST_HALTED;
                    end
                endcase
            end
            ST_ISSUE: begin
                inc_retired = 1'b1;
                state_next  = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                if (resolved_misaligned) begin
                    set_fault  = 1'b1;
                    state_next = ST_HALTED;
                end else begin
                    load_next  = 1'b1;
                    state_next = stop ? ST_IDLE : ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered datapath and status outputs; status flags are computed
    // from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg       <= 32'd0;
            opcode_reg   <= 32'd0;
            push_ops_reg <= 1'b0;
            busy_reg     <= 1'b0;
            halted_reg   <= 1'b0;
            fault_reg    <= 1'b0;
            retired_reg  <= 32'd0;
        end else begin
            if (load_boot) begin
                pc_reg <= boot_pc;
            end else if (load_next) begin
                pc_reg <= resolved_pc;
            end

            if (load_boot) begin
                fault_reg <= set_fault;
            end else if (set_fault) begin
                fault_reg <= 1'b1;
            end

            if (load_boot) begin
                retired_reg <= 32'd0;
            end else if (inc_retired) begin
                retired_reg <= retired_reg + 32'd1;
            end

            if (load_opcode) begin
                opcode_reg <= imem_rdata;
            end

            push_ops_reg <= (state_next == ST_ISSUE);
            busy_reg     <= (state_next == ST_FETCH)   || (state_next == ST_CAPTURE) ||
                            (state_next == ST_ISSUE)   || (state_next == ST_RESOLVE);
            halted_reg   <= (state_next == ST_HALTED);
        end
    end

    // SRAM request is decoded directly from state and PC so the read is
    // launched in FETCH and its data is present in CAPTURE.
    assign imem_en   = (state_reg == ST_FETCH);
    assign imem_addr = pc_reg[IMEM_AW+1:2];

    assign push_ops  = push_ops_reg;
    assign opcode    = opcode_reg;
    assign pc        = pc_reg;
    assign busy      = busy_reg;
    assign halted    = halted_reg;
    assign fault     = fault_reg;
    assign retired   = retired_reg;

endmodule

// File: tb/tb_hy_riscv_fetch_issue.sv
// Bench for hy_riscv_fetch_issue: an SRAM model, a CPU stub that returns a
// pre-chosen branch result per push, and an instruction-level reference walk
// of the program that predicts the issued stream and the final status.
module tb_hy_riscv_fetch_issue;

    localparam int K_ALU  = 0;
    localparam int K_BR   = 1;
    localparam int K_JAL  = 2;
    localparam int K_JALR = 3;
    localparam int K_ILL  = 4;
    localparam int K_ZERO = 5;
    localparam int K_SYS  = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] boot_pc = 32'd0;
    logic        stop = 1'b0;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        push_ops;
    logic [31:0] opcode;
    logic        branch_taken = 1'b0;
    logic [31:0] pc;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    hy_riscv_fetch_issue #(.IMEM_AW(10), .HALT_ON_ZERO(1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .boot_pc      (boot_pc),
        .stop         (stop),
        .imem_en      (imem_en),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .push_ops     (push_ops),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .pc           (pc),
        .busy         (busy),
        .halted       (halted),
        .fault        (fault),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Program image: encoded word plus the kind/offset it was built from
    logic [31:0] mem_word [1024];
    int          mem_kind [1024];
    int          mem_off  [1024];
    logic        taken_tab [64];

    always @(posedge clk) if (imem_en) imem_rdata <= mem_word[imem_addr];

    // CPU stub: registers a branch result on each push edge
    int tk_idx = 0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_taken <= 1'b0;
            tk_idx <= 0;
        end else if (start) begin
            tk_idx <= 0;
        end else if (push_ops) begin
            branch_taken <= taken_tab[tk_idx % 64];
            tk_idx <= tk_idx + 1;
        end
    end

    typedef struct { int c; logic [31:0] p; logic [31:0] w; } push_t;
    push_t obs_q[$];
    logic [9:0] last_fetch = 10'd0;

    always @(negedge clk) begin
        if (push_ops) obs_q.push_back('{cyc, pc, opcode});
        if (imem_en) last_fetch <= imem_addr;
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_b(input logic [31:0] off);
        return {off[12], off[10:5], 5'd2, 5'd1, 3'b000, off[4:1], off[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] off);
        return {off[20], off[10:1], off[11], off[19:12], 5'd1, 7'h6F};
    endfunction

    task automatic put(input int w, input int kind, input int off);
        logic [31:0] r;
        r = $urandom;
        mem_kind[w] = kind;
        mem_off[w]  = off;
        case (kind)
            K_ALU:   mem_word[w] = {r[31:7], 7'h13};
            K_BR:    mem_word[w] = enc_b(32'(off));
            K_JAL:   mem_word[w] = enc_j(32'(off));
            K_JALR:  mem_word[w] = {r[31:7], 7'h67};
            K_ILL:   mem_word[w] = {r[31:2], 2'b01};
            K_ZERO:  mem_word[w] = 32'd0;
            default: mem_word[w] = 32'h0000_0073;
        endcase
    endtask

    task automatic clear_mem();
        for (int w = 0; w < 1024; w++) put(w, K_SYS, 0);
    endtask

    // Reference walk over the program at instruction level
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_op_q[$];
    logic [31:0] exp_final_pc;
    logic        exp_fault;
    int          exp_ret;

    task automatic model(input logic [31:0] boot);
        logic [31:0] p;
        logic [31:0] n;
        int w;
        int k;
        exp_pc_q.delete();
        exp_op_q.delete();
        exp_fault = 1'b0;
        k = 0;
        p = boot;
        if (boot % 4 != 0) begin
            exp_fault = 1'b1;
        end else begin
            for (int it = 0; it < 1000; it++) begin
                w = int'((p % 4096) / 4);
                if (mem_kind[w] == K_SYS || mem_kind[w] == K_ZERO) break;
                if (mem_kind[w] == K_ILL || mem_kind[w] == K_JALR) begin
                    exp_fault = 1'b1;
                    break;
                end
                exp_pc_q.push_back(p);
                exp_op_q.push_back(mem_word[w]);
                n = p + 32'd4;
                if (mem_kind[w] == K_JAL) n = p + 32'(mem_off[w]);
                if (mem_kind[w] == K_BR && taken_tab[k % 64]) n = p + 32'(mem_off[w]);
                k++;
                if (n % 4 != 0) begin
                    exp_fault = 1'b1;
                    break;
                end
                p = n;
            end
        end
        exp_final_pc = p;
        exp_ret = k;
    endtask

    task automatic run_case(input string tag, input logic [31:0] boot);
        int start_cyc;
        logic done;
        int n;
        model(boot);
        obs_q.delete();
        boot_pc = boot;
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (halted || !busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_npush"}, 32'(obs_q.size()), 32'(exp_pc_q.size()));
        n = (obs_q.size() < exp_pc_q.size()) ? obs_q.size() : exp_pc_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_pc%0d", tag, i), obs_q[i].p, exp_pc_q[i]);
            check($sformatf("%s_op%0d", tag, i), obs_q[i].w, exp_op_q[i]);
            check($sformatf("%s_cyc%0d", tag, i), 32'(obs_q[i].c), 32'(start_cyc + 3 + 4 * i));
        end
        check({tag, "_pc"}, pc, exp_final_pc);
        check({tag, "_fault"}, 32'(fault), 32'(exp_fault));
        check({tag, "_halted"}, 32'(halted), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_retired"}, retired, 32'(exp_ret));
    endtask

    task automatic build_random(input int base, input int len);
        int r;
        int off;
        clear_mem();
        for (int i = 0; i < 64; i++) taken_tab[i] = 1'($urandom_range(0, 1));
        for (int w = base; w < base + len; w++) begin
            r = $urandom_range(0, 99);
            off = 4 * $urandom_range(1, 3) + (($urandom_range(0, 7) == 0) ? 2 : 0);
            if (r < 50)      put(w, K_ALU, 0);
            else if (r < 70) put(w, K_BR, off);
            else if (r < 80) put(w, K_JAL, off);
            else if (r < 85) put(w, K_JALR, 0);
            else if (r < 90) put(w, K_ILL, 0);
            else if (r < 95) put(w, K_ZERO, 0);
            else             put(w, K_SYS, 0);
        end
    endtask

    initial begin
        logic got;
        int base;
        for (int i = 0; i < 64; i++) taken_tab[i] = 1'b0;
        clear_mem();

        // Reset values
        reset_n = 1'b0;
        step();
        step();
        check("rst_pc", pc, 32'd0);
        check("rst_opcode", opcode, 32'd0);
        check("rst_push", 32'(push_ops), 32'd0);
        check("rst_imem_en", 32'(imem_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_retired", retired, 32'd0);
        reset_n = 1'b1;
        step();

        // Straight line: three ALU ops then ECALL
        clear_mem();
        put(0, K_ALU, 0); put(1, K_ALU, 0); put(2, K_ALU, 0);
        run_case("line", 32'h0);
        check("line_ret3", retired, 32'd3);
        check("line_pcC", pc, 32'h0000_000C);

        // Taken and not-taken BEQ -8 at 0x10
        clear_mem();
        put(4, K_BR, -8);
        taken_tab[0] = 1'b1;
        run_case("br_t", 32'h10);
        check("br_t_fetch", 32'(last_fetch), 32'd2);
        taken_tab[0] = 1'b0;
        run_case("br_nt", 32'h10);
        check("br_nt_pc", pc, 32'h14);

        // JAL +0x20 at 0x04, then wrap past the top of the 4 KB window
        clear_mem();
        put(1, K_JAL, 32'h20);
        run_case("jal", 32'h4);
        check("jal_pc", pc, 32'h24);
        clear_mem();
        put(1023, K_ALU, 0);
        run_case("wrap", 32'hFFC);
        check("wrap_fetch", 32'(last_fetch), 32'd0);
        check("wrap_pc", pc, 32'h1000);

        // Faults: misaligned boot, JALR after one issued instruction
        clear_mem();
        run_case("boot2", 32'h2);
        check("boot2_fault", 32'(fault), 32'd1);
        put(0, K_ALU, 0);
        put(1, K_JALR, 0);
        run_case("jalr", 32'h0);
        check("jalr_ret", retired, 32'd1);

        // Randomized forward-only programs
        for (int t = 0; t < 8; t++) begin
            base = $urandom_range(0, 900);
            build_random(base, 14);
            run_case($sformatf("rnd%0d", t), 32'(base * 4));
        end

        // Stop held during the second instruction; start while busy ignored
        clear_mem();
        for (int w = 0; w < 6; w++) put(w, K_ALU, 0);
        obs_q.delete();
        boot_pc = 32'h0;
        start = 1'b1;
        step();
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (obs_q.size() >= 1) begin got = 1'b1; break; end
            step();
        end
        check("stop_first_push", 32'(got), 32'd1);
        step();
        step();
        stop = 1'b1;
        boot_pc = 32'h100;
        start = 1'b1;
        step();
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!busy) begin got = 1'b1; break; end
            step();
        end
        stop = 1'b0;
        check("stop_done", 32'(got), 32'd1);
        check("stop_pc", pc, 32'h8);
        check("stop_halted", 32'(halted), 32'd0);
        check("stop_retired", retired, 32'd2);
        check("stop_npush", 32'(obs_q.size()), 32'd2);
        check("stop_fault", 32'(fault), 32'd0);

        // Reset asserted while the second instruction is being issued
        obs_q.delete();
        boot_pc = 32'h0;
        start = 1'b1;
        step();
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (obs_q.size() >= 2) begin got = 1'b1; break; end
            step();
        end
        check("mid_second_push", 32'(got), 32'd1);
        check("mid_push_before", 32'(push_ops), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_push", 32'(push_ops), 32'd0);
        check("mid_pc", pc, 32'd0);
        check("mid_opcode", opcode, 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_retired", retired, 32'd0);
        check("mid_imem_en", 32'(imem_en), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("mid_idle_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
